// File: rtl/fmul_share_arbiter_if.sv
// Signal bundle between the requesters, the shared float multiplier and fmul_share_arbiter.
// The arbiter side uses the slave modport; the master side drives requests, acks and mul_z.
interface fmul_share_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [32*NREQ-1:0]   resp_z;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic                 mul_en;
    logic [31:0]          mul_z;
    logic [NREQ-1:0]      busy;
    logic                 idle;

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_z,
        input  req_ready, resp_valid, resp_z, mul_a, mul_b, mul_en, busy, idle
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_z,
        output req_ready, resp_valid, resp_z, mul_a, mul_b, mul_en, busy, idle
    );
endinterface

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one fixed-latency float multiplier among NREQ requesters,
// with an id shift register tracking in-flight ops and a one-entry result buffer per requester.
module fmul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 3
) (
    input  logic               clk,
    input  logic               clrn,
    fmul_share_arbiter_if.slave bus
);
    logic [NREQ-1:0][31:0]     w_req_a;
    logic [NREQ-1:0][31:0]     w_req_b;
    logic [NREQ-1:0]           w_elig;
    logic [NREQ-1:0]           w_ready;
    logic [NREQ-1:0]           w_ack;
    logic                      w_issue;
    logic [IDW-1:0]            w_gnt;
    logic [IDW:0]              w_sum;

    logic [IDW-1:0]            r_ptr;
    logic [NREQ-1:0]           r_busy;
    logic [NREQ-1:0]           r_resp_valid;
    logic [NREQ-1:0][31:0]     r_resp_z;
    logic [31:0]               r_mul_a;
    logic [31:0]               r_mul_b;
    logic                      r_mul_en;
    logic [LAT-1:0]            r_sr_valid;
    logic [LAT-1:0][IDW-1:0]   r_sr_id;

    assign w_req_a = bus.req_a;
    assign w_req_b = bus.req_b;
    assign w_elig  = bus.req_valid & ~r_busy;
    assign w_ack   = r_resp_valid & bus.resp_ready;

    // Grant is gated by clrn so req_ready stays low while reset is held.
    always_comb begin
        w_issue = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (clrn && !w_issue && w_elig[w_sum[IDW-1:0]]) begin
                w_issue = 1'b1;
                w_gnt   = w_sum[IDW-1:0];
            end
        end
    end

    assign w_ready = w_issue ? (NREQ'(1) << w_gnt) : '0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ptr        <= '0;
            r_busy       <= '0;
            r_resp_valid <= '0;
            r_resp_z     <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_en     <= 1'b0;
            r_sr_valid   <= '0;
            r_sr_id      <= '0;
        end else begin
            r_mul_en      <= 1'b1;
            r_sr_valid[0] <= w_issue;
            r_sr_id[0]    <= w_gnt;
            for (int s = 1; s < LAT; s++) begin
                r_sr_valid[s] <= r_sr_valid[s-1];
                r_sr_id[s]    <= r_sr_id[s-1];
            end
            if (w_issue) begin
                r_mul_a <= w_req_a[w_gnt];
                r_mul_b <= w_req_b[w_gnt];
                if (w_gnt == IDW'(NREQ-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt + 1'b1;
                end
            end
            // The credit rule keeps a completing id disjoint from any id being acked.
            r_busy       <= (r_busy & ~w_ack) | w_ready;
            r_resp_valid <= r_resp_valid & ~w_ack;
            if (r_sr_valid[LAT-1]) begin
                r_resp_valid[r_sr_id[LAT-1]] <= 1'b1;
                r_resp_z[r_sr_id[LAT-1]]     <= bus.mul_z;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_z     = r_resp_z;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.mul_en     = r_mul_en;
    assign bus.busy       = r_busy;
    assign bus.idle       = ~|bus.req_valid & ~|r_busy;
endmodule

// File: doc/fmul_share_arbiter.md
Name: fmul_share_arbiter

Overview:
- Shares one pipelined single-precision float multiplier among NREQ requesters.
- Round-robin arbitration, one issue per cycle.
- Tracks in-flight operations with an id shift register matched to the multiplier latency.
- Routes each result into a per-requester one-entry response buffer with valid/ready handshake.
- Sits between client units (e.g. FPU issue ports) and the multiplier pipeline (partial product, CLA add, normalize).

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester id width, must be >= clog2(NREQ)
- LAT, 3, number of clk edges from operands driven on mul_a/mul_b until mul_z is valid for them

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  per-requester grant; a handshake occurs when valid & ready are both high at a rising edge
- req_a  in  32*NREQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing as req_a
- resp_valid  out  NREQ  per-requester result available
- resp_ready  in  NREQ  per-requester result accepted
- resp_z  out  32*NREQ  per-requester result, same packing as req_a
- mul_a  out  32  operand A to multiplier, registered
- mul_b  out  32  operand B to multiplier, registered
- mul_en  out  1  multiplier pipeline enable
- mul_z  in  32  multiplier result
- busy  out  NREQ  requester i has an operation in flight or an unconsumed result
- idle  out  1  no request pending, nothing in flight, all response buffers empty

Behaviour:
- Reset (clrn low, async):
  - req_ready=0, resp_valid=0, resp_z=0, mul_a=0, mul_b=0, mul_en=0, busy=0, idle=1.
  - Round-robin pointer=0; in-flight shift register cleared.
  - Reset mid-operation discards all in-flight ops and buffered results; no stale resp_valid after release.
- mul_en: 0 in reset, 1 from the first rising edge after clrn release, then held at 1. The pipeline never stalls.
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0. Each requester has one credit, so at most one op per requester is in flight or buffered.
- Arbitration:
  - Combinational, round-robin.
  - Search starts at the pointer and goes upward with wrap, NREQ-1 to 0.
  - The first eligible requester g gets req_ready[g]=1; every other req_ready is 0.
  - req_ready is never asserted for a non-eligible requester.
- Issue at edge E0 (handshake on g):
  - mul_a<=req_a[g], mul_b<=req_b[g].
  - busy[g]<=1.
  - Pointer<=(g+1) mod NREQ.
  - Shift-register stage 0 <= {valid=1, id=g}.
  - With no handshake, stage 0 gets valid=0 and mul_a/mul_b hold their value. The pointer is unchanged.
- In-flight tracking: a LAT-deep shift register of {valid, id}, advanced every edge.
- Completion:
  - The tail entry is valid at edge E0+LAT. At that edge resp_z[id]<=mul_z and resp_valid[id]<=1.
  - Request-handshake to resp_valid high = LAT+1 cycles.
  - Sustained throughput is one op per cycle across different requesters.
- Response:
  - resp_valid[i] and resp_z[i] hold until resp_ready[i]=1 at an edge.
  - At that edge resp_valid[i]<=0 and busy[i]<=0.
  - Requester i becomes eligible again in the following cycle, so per-requester back-to-back issue interval >= LAT+2 cycles.
- Simultaneous events:
  - A completion for one requester and an issue for a different requester in the same edge are both performed.
  - A completion can never target a buffer with resp_valid=1, because the credit rule prevents it.
  - resp_ready with resp_valid=0 is ignored.
- idle = ~|req_valid & ~|busy, combinational.
- Exceptions and NaN handling are left to the multiplier; results are passed through unmodified.

Test Plan:
- Reset, then requester 1 presents a=0x40000000 (2.0), b=0x40400000 (3.0), resp_ready=1.
  - req_ready[1] rises in the same cycle.
  - resp_valid[1]=1 with resp_z[1]=0x40C00000 exactly LAT+1 cycles later, for one cycle.
  - busy[1] clears at the next edge.
- All four requesters valid continuously, each with distinct operands, and resp_ready held at 1.
  - Grants go in the order 0,1,2,3.
  - Four issues occur on four consecutive edges.
  - Results arrive on consecutive cycles, each with the correct resp_z[i].
- Requester 2 holds resp_ready[2]=0 for 10 cycles after its result.
  - resp_z[2] stays stable and busy[2]=1; req_ready[2] stays 0 while req_valid[2]=1.
  - Other requesters keep issuing.
- Assert clrn low while 3 ops are in flight.
  - All outputs take their reset values immediately.
  - After release, no resp_valid appears for the 6 following cycles.
- Requesters 0 and 3 are both valid and the pointer is at 3 (after a grant to 2).
  - The grant goes to 3 and the pointer moves to 0.
  - The next grant goes to 0 once 0 is eligible.
- Special operands +inf*0 (0x7F800000 * 0x00000000): the result equals the multiplier output (a NaN pattern), routed to the correct requester.
